// File: rtl/tiny_soc_mmio_responder.sv
// ---------------------------------------------------------------------------
// tiny_soc_mmio_responder
//
// MMIO register target that sits on the core's MMIO request port. It lets a
// simulation or fuzzing bench see when the program stops and what it prints.
// Register map, one 64-bit register every 8 bytes from BaseAddr:
//   0 STOP      sticky stop flag + 32-bit exit code (first write wins)
//   1 SCRATCH   byte-strobed read/write
//   2 MTIME     free-running 64-bit timer; a write replaces strobed bytes
//   3 MTIMECMP  byte-strobed compare value for timer_irq_o
//   4 CONSOLE   a write with strb[0] pushes wdata[7:0] into the console FIFO
//   5 STATUS    read-only {30'b0, irq, stop, drop count, FIFO count}
//
// Request handshake: mmio_req_i is a single-cycle request that is always
// accepted (there is no ready). Read data comes back in mmio_rdata_o one cycle
// later and holds until the next read. Console handshake: a byte moves when
// cons_valid_o && cons_ready_i are both high at a rising clock edge.
// cons_data_o is stable while cons_valid_o is high and the sink is not ready.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   mmio_req_i/we_i/addr_i/strb_i/wdata_i   request
//   mmio_rdata_o                   registered read data
//   stop_o, stop_code_o            sticky stop flag and exit code
//   timer_irq_o                    registered MTIME >= MTIMECMP
//   cons_valid_o, cons_data_o, cons_ready_i  console byte stream
//   bad_access_o                   sticky: an unmapped address was accessed
// ---------------------------------------------------------------------------
module tiny_soc_mmio_responder #(
    parameter int                         MMIOAddrWidth = 31,
    parameter int                         DataWidth     = 64,
    parameter logic [MMIOAddrWidth-1:0]   BaseAddr      = 31'h1000_0000,
    parameter int                         ConsDepth     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       mmio_req_i,
    input  logic                       mmio_we_i,
    input  logic [MMIOAddrWidth-1:0]   mmio_addr_i,
    input  logic [DataWidth/8-1:0]     mmio_strb_i,
    input  logic [DataWidth-1:0]       mmio_wdata_i,
    output logic [DataWidth-1:0]       mmio_rdata_o,
    output logic                       stop_o,
    output logic [31:0]                stop_code_o,
    output logic                       timer_irq_o,
    output logic                       cons_valid_o,
    output logic [7:0]                 cons_data_o,
    input  logic                       cons_ready_i,
    output logic                       bad_access_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int PtrW      = $clog2(ConsDepth);
    localparam int CntW      = PtrW + 1;
    localparam int HiW       = MMIOAddrWidth - 3;
    localparam logic [HiW-1:0] BaseHi = BaseAddr[MMIOAddrWidth-1:3];

    // Byte-lane merge shared by every strobed register.
    function automatic logic [DataWidth-1:0] merge_bytes(
        input logic [DataWidth-1:0] cur,
        input logic [DataWidth-1:0] wd,
        input logic [StrbWidth-1:0] strb
    );
        logic [DataWidth-1:0] res;
        res = cur;
        for (int b = 0; b < StrbWidth; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    // ---------------- address decode ----------------
    // BaseAddr is 8-byte aligned, so comparing and subtracting on the
    // doubleword part of the address is exact; bits [2:0] play no role.
    logic [HiW-1:0] addr_hi;
    logic [HiW-1:0] idx_full;
    logic [2:0]     idx;
    logic [2:0]     unused_addr_bits;
    logic           mapped;
    logic           rd_en;
    logic           wr_en;

    assign addr_hi          = mmio_addr_i[MMIOAddrWidth-1:3];
    assign unused_addr_bits = mmio_addr_i[2:0];
    assign idx_full         = addr_hi - BaseHi;
    assign mapped           = (addr_hi >= BaseHi) && (idx_full <= HiW'(5));
    assign idx              = idx_full[2:0];
    assign rd_en            = mmio_req_i && !mmio_we_i;
    assign wr_en            = mmio_req_i && mmio_we_i && mapped;

    // ---------------- state ----------------
    logic [DataWidth-1:0] rdata_q, scratch_q, mtime_q, mtimecmp_q, rd_val;
    logic                 stop_q, irq_q, bad_q;
    logic [31:0]          stop_code_q;
    logic [7:0]           fifo_mem [ConsDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic [15:0]          drop_q;
    logic                 fifo_full, push_req, pop, push_ok, drop_inc;

    // ---------------- read mux (values before this cycle's updates) ----------------
    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0: rd_val = {31'b0, stop_q, stop_code_q};
            3'd1: rd_val = scratch_q;
            3'd2: rd_val = mtime_q;
            3'd3: rd_val = mtimecmp_q;
            3'd5: rd_val = {30'b0, irq_q, stop_q, drop_q, {(16-CntW){1'b0}}, count_q};
            default: rd_val = '0;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q     <= '0;
            scratch_q   <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '0;
            stop_q      <= 1'b0;
            stop_code_q <= '0;
            irq_q       <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            if (rd_en) rdata_q <= mapped ? rd_val : '0;
            if (mmio_req_i && !mapped) bad_q <= 1'b1;
            if (wr_en && idx == 3'd0 && |mmio_strb_i[3:0] && !stop_q) begin
                stop_q      <= 1'b1;
                stop_code_q <= mmio_wdata_i[31:0];
            end
            if (wr_en && idx == 3'd1) scratch_q <= merge_bytes(scratch_q, mmio_wdata_i, mmio_strb_i);
            // A write to MTIME replaces the increment for that cycle.
            if (wr_en && idx == 3'd2) mtime_q <= merge_bytes(mtime_q, mmio_wdata_i, mmio_strb_i);
            else                      mtime_q <= mtime_q + 64'd1;
            if (wr_en && idx == 3'd3) mtimecmp_q <= merge_bytes(mtimecmp_q, mmio_wdata_i, mmio_strb_i);
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    // ---------------- console FIFO ----------------
    assign fifo_full = (count_q == CntW'(ConsDepth));
    assign push_req  = wr_en && (idx == 3'd4) && mmio_strb_i[0];
    assign pop       = cons_valid_o && cons_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop_inc  = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ConsDepth; i++) fifo_mem[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr_q] <= mmio_wdata_i[7:0];
                wr_ptr_q           <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    // ---------------- outputs ----------------
    assign mmio_rdata_o = rdata_q;
    assign stop_o       = stop_q;
    assign stop_code_o  = stop_code_q;
    assign timer_irq_o  = irq_q;
    assign bad_access_o = bad_q;
    assign cons_valid_o = (count_q != '0);
    assign cons_data_o  = fifo_mem[rd_ptr_q];

endmodule

// File: doc/tiny_soc_mmio_responder.md
# tiny_soc_mmio_responder

MMIO register target for the tiny SoC, sitting on the core's MMIO request port: it takes single-cycle MMIO requests (address, byte strobes, write data, write enable) and returns registered read data. It exposes a sticky stop/exit register, a scratch register, a free-running 64-bit timer with compare interrupt, and a byte console drained through a small FIFO, so fuzzing and simulation benches can observe program termination and console output.

## Interface
- MMIOAddrWidth, 31, MMIO address width
- DataWidth, 64, data width (fixed at 64; StrbWidth = 8)
- BaseAddr, 31'h1000_0000, byte address of register 0; must be 8-byte aligned
- ConsDepth, 8, console FIFO depth (power of two, >= 2)
- clk_i  input  1  clock; all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- mmio_req_i  input  1  request valid this cycle; always accepted (no backpressure)
- mmio_we_i  input  1  1 = write, 0 = read
- mmio_addr_i  input  MMIOAddrWidth  byte address; bits [2:0] ignored
- mmio_strb_i  input  8  byte strobes for writes; ignored for reads
- mmio_wdata_i  input  64  write data
- mmio_rdata_o  output  64  read data, registered
- stop_o  output  1  sticky stop flag
- stop_code_o  output  32  code from first STOP write
- timer_irq_o  output  1  registered MTIME >= MTIMECMP
- cons_valid_o  output  1  console byte available
- cons_data_o  output  8  console byte (FIFO head)
- cons_ready_i  input  1  console sink accepts byte when valid
- bad_access_o  output  1  sticky: any request to an unmapped address

## Operation
- Decode: idx = (mmio_addr_i - BaseAddr) >> 3; mapped iff mmio_addr_i >= BaseAddr and idx <= 5.
- idx 0 STOP: write with any of strb[3:0] set, while stop_o = 0 -> stop_o <= 1, stop_code_o <= wdata[31:0]. Later writes ignored. Read = {31'b0, stop_o, stop_code_o}.
- idx 1 SCRATCH: RW; bytes merged per strobe.
- idx 2 MTIME: increments by 1 every cycle (wraps 2^64-1 -> 0). On write, strobed bytes take wdata, unstrobed bytes keep the current value; no increment that cycle.
- idx 3 MTIMECMP: RW per strobe. timer_irq_o <= (MTIME >= MTIMECMP), unsigned, evaluated on current register values each cycle.
- idx 4 CONSOLE: write with strb[0] pushes wdata[7:0]. If FIFO full and no pop this cycle -> byte dropped, drop counter +1 (16-bit, saturates at 16'hFFFF). Full with simultaneous pop -> push accepted. Read = 0.
- idx 5 STATUS (read-only, writes ignored): [15:0] FIFO count, [31:16] drop count, [32] stop_o, [33] timer_irq_o, rest 0.
- Unmapped read -> rdata 0; unmapped write -> no state change; both set bad_access_o.
- Console FIFO: pop when cons_valid_o && cons_ready_i; cons_valid_o = count != 0; cons_data_o = head entry; pointers wrap modulo ConsDepth.

## Timing
- Reset values: mmio_rdata_o 0, stop_o 0, stop_code_o 0, timer_irq_o 0, cons_valid_o 0, cons_data_o 0, bad_access_o 0; MTIME, MTIMECMP, SCRATCH, drop count, FIFO pointers/count 0. Reset mid-operation discards FIFO contents and any pending read data.
- Read latency 1: read in cycle N -> mmio_rdata_o valid from cycle N+1, holds until the next read request's result is loaded. Writes never change mmio_rdata_o.
- Read returns register value at cycle N (before cycle-N updates); MTIME read in cycle N returns the value from which cycle N's increment occurs.
- Write effects visible from cycle N+1 (register, stop_o, FIFO count). No fall-through: push into empty FIFO in cycle N -> cons_valid_o = 1 in N+1.
- timer_irq_o lags register state by one cycle: MTIMECMP written in N -> irq reflects new compare in N+2.
- Back-to-back requests every cycle supported.

## Test plan
- Reset, then read STATUS -> rdata 0 next cycle; idle 10 cycles, read MTIME at cycle N -> value equals cycles since reset release at N, with successive reads 1 apart per cycle.
- Write SCRATCH 64'h1122334455667788 strb 8'hFF, then strb 8'h0F with 64'hAAAAAAAA_BBBBBBBB -> read 64'h11223344_BBBBBBBB.
- Write STOP 32'h1, then STOP 32'h5 -> stop_o = 1, stop_code_o = 32'h1; STOP read = {31'b0, 1'b1, 32'h1}.
- cons_ready_i = 0, push 10 bytes (ConsDepth 8) -> count 8, drop count 2; raise ready -> first 8 bytes emerge in order, one per cycle, cons_valid_o low after; push while full with ready = 1 -> accepted.
- MTIMECMP = 20 after reset -> timer_irq_o rises exactly one cycle after MTIME reaches 20; write MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF -> irq drops.
- Read and write BaseAddr + 0x30 and an address below BaseAddr -> rdata 0, bad_access_o = 1 sticky, no register changes.
